payload_char_feeder: RTL and testbench

Byte-stream front end for the payload regex engines. It accepts packet payload bytes over a valid/ready stream and looks each byte up in a programmable 256-entry character-class table. Each byte is then driven to the engine array as a one-hot/multi-hot class vector with a per-byte `en` strobe. The block also sequences the engine-side `sod` clear before each packet, and an `eod` strobe once engine match flags have settled.

---
 rtl/payload_char_feeder.sv | 141 ++++++++++++++
 tb/tb_payload_char_feeder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/payload_char_feeder.sv
// Byte-to-class front end for the payload regex engine array; sequences sod/en/eod per packet.
// Latency: byte accepted at t gives en/char_class at t+1; eod three cycles after the EOP byte is accepted.
// Backpressure: s_ready low in SOD/FLUSH/EOD and under rst; orphan bytes in IDLE are always drained.
// Optional byte counter output enabled by PAYLOAD_FEEDER_BYTE_CNT_EN.
module payload_char_feeder #(
    parameter int NUM_CLASSES = 35
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             s_data,
    input  logic                   s_valid,
    input  logic                   s_sop,
    input  logic                   s_eop,
    output logic                   s_ready,
    input  logic                   cfg_we,
    input  logic [7:0]             cfg_addr,
    input  logic [NUM_CLASSES-1:0] cfg_data,
    output logic [NUM_CLASSES-1:0] char_class,
    output logic                   en,
    output logic                   sod,
    output logic                   eod,
    output logic                   err
`ifdef PAYLOAD_FEEDER_BYTE_CNT_EN
    ,
    output logic [15:0]            byte_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        SOD,
        STREAM,
        FLUSH,
        EOD
    } state_t;

    state_t                 state;
    logic                   first_byte;
    logic                   accept;
    logic                   sop_start;
    logic                   orphan;
    logic                   sop_dup;
    logic                   cfg_ok;
    logic                   cfg_drop;
    logic [NUM_CLASSES-1:0] class_table [256];

    always_comb begin
        s_ready = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:    s_ready = s_valid && !s_sop;
                STREAM:  s_ready = 1'b1;
                default: s_ready = 1'b0;
            endcase
        end
    end

    assign accept    = s_valid && s_ready;
    assign sop_start = (state == IDLE) && s_valid && s_sop;
    assign orphan    = accept && (state == IDLE);
    assign sop_dup   = accept && (state == STREAM) && s_sop && !first_byte;
    assign cfg_ok    = cfg_we && (state == IDLE) && !rst;
    assign cfg_drop  = cfg_we && (state != IDLE);

    // Table contents survive rst; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (cfg_ok) begin
            class_table[cfg_addr] <= cfg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            char_class <= '0;
        end else if (accept && (state == STREAM)) begin
            char_class <= class_table[s_data];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            first_byte <= 1'b0;
            sod        <= 1'b0;
            en         <= 1'b0;
            eod        <= 1'b0;
            err        <= 1'b0;
        end else begin
            sod <= 1'b0;
            en  <= 1'b0;
            eod <= 1'b0;
            err <= orphan || sop_dup || cfg_drop;
            case (state)
                IDLE: begin
                    if (sop_start) begin
                        state <= SOD;
                        sod   <= 1'b1;
                    end
                end
                SOD: begin
                    state      <= STREAM;
                    first_byte <= 1'b1;
                end
                STREAM: begin
                    if (accept) begin
                        en         <= 1'b1;
                        first_byte <= 1'b0;
                        if (s_eop) begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    state <= EOD;
                end
                EOD: begin
                    // eod lands one cycle after EOD so engine out flags have passed
                    // both the state flop and the sticky end flop.
                    state <= IDLE;
                    eod   <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef PAYLOAD_FEEDER_BYTE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt <= 16'd0;
        end else if (sop_start) begin
            byte_cnt <= 16'd0;
        end else if (en && (byte_cnt != 16'hFFFF)) begin
            byte_cnt <= byte_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_payload_char_feeder.sv
// Directed bench for payload_char_feeder: per-cycle output log plus scenario tasks.
module tb_payload_char_feeder;
    localparam int NC   = 35;
    localparam int LOGN = 512;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    s_data = 8'h00;
    logic          s_valid = 1'b0;
    logic          s_sop = 1'b0;
    logic          s_eop = 1'b0;
    logic          s_ready;
    logic          cfg_we = 1'b0;
    logic [7:0]    cfg_addr = 8'h00;
    logic [NC-1:0] cfg_data = '0;
    logic [NC-1:0] char_class;
    logic          en, sod, eod, err;
`ifdef PAYLOAD_FEEDER_BYTE_CNT_EN
    logic [15:0]   byte_cnt;
`endif

    int nvec = 0;
    int nmis = 0;
    int cyc  = 0;

    logic          en_l  [LOGN];
    logic          sod_l [LOGN];
    logic          eod_l [LOGN];
    logic          err_l [LOGN];
    logic [NC-1:0] cc_l  [LOGN];
    logic [7:0]    pkt   [16];

    payload_char_feeder #(.NUM_CLASSES(NC)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_sop(s_sop),
        .s_eop(s_eop), .s_ready(s_ready), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .char_class(char_class), .en(en), .sod(sod),
        .eod(eod), .err(err)
`ifdef PAYLOAD_FEEDER_BYTE_CNT_EN
        , .byte_cnt(byte_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        en_l[cyc % LOGN]  <= en;
        sod_l[cyc % LOGN] <= sod;
        eod_l[cyc % LOGN] <= eod;
        err_l[cyc % LOGN] <= err;
        cc_l[cyc % LOGN]  <= char_class;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic int cnt(input int sel, input int a, input int b);
        int c = 0;
        for (int i = a; i <= b; i++) begin
            case (sel)
                0:       c += int'(en_l[i % LOGN]);
                1:       c += int'(sod_l[i % LOGN]);
                2:       c += int'(eod_l[i % LOGN]);
                default: c += int'(err_l[i % LOGN]);
            endcase
        end
        return c;
    endfunction

    task automatic drive_pkt(input int n, input int gap_at, input int gap_len,
                             input int sop_at, input int cfg_at, output int t_sop);
        int guard;
        t_sop = cyc;
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
                repeat (gap_len) step;
            end
            s_valid = 1'b1;
            s_data  = pkt[i];
            s_sop   = (i == 0) || (i == sop_at);
            s_eop   = (i == n - 1);
            if (i == 0) t_sop = cyc;
            if (i == cfg_at) begin
                cfg_we = 1'b1; cfg_addr = 8'h41; cfg_data = 35'h7;
            end
            guard = 0;
            @(negedge clk);
            while (!s_ready && guard < 20) begin
                step;
                cfg_we = 1'b0;
                @(negedge clk);
                guard++;
            end
            nvec++;
            if (!s_ready) begin
                nmis++;
                $display("FAIL pkt_accept byte %0d: s_ready=%b after %0d cycles, required 1", i, s_ready, guard);
            end
            step;
            cfg_we = 1'b0;
        end
        s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; s_valid = 1'b1; s_sop = 1'b0; s_data = 8'h41;
        repeat (3) step;
        @(negedge clk);
        nvec++; if (s_ready !== 1'b0) begin nmis++; $display("FAIL reset_s_ready got %b required 0", s_ready); end
        nvec++; if (en !== 1'b0) begin nmis++; $display("FAIL reset_en got %b required 0", en); end
        nvec++; if (sod !== 1'b0) begin nmis++; $display("FAIL reset_sod got %b required 0", sod); end
        nvec++; if (eod !== 1'b0) begin nmis++; $display("FAIL reset_eod got %b required 0", eod); end
        nvec++; if (err !== 1'b0) begin nmis++; $display("FAIL reset_err got %b required 0", err); end
        nvec++; if (char_class !== '0) begin nmis++; $display("FAIL reset_char_class got %h required 0", char_class); end
`ifdef PAYLOAD_FEEDER_BYTE_CNT_EN
        nvec++; if (byte_cnt !== 16'd0) begin nmis++; $display("FAIL reset_byte_cnt got %h required 0", byte_cnt); end
`endif
        step;
        rst = 1'b0; s_valid = 1'b0;
        step;
    endtask

    task automatic test_program_stream;
        int t;
        int t0;
        t0 = cyc;
        for (int a = 0; a < 256; a++) begin
            cfg_we   = 1'b1;
            cfg_addr = 8'(a);
            cfg_data = (a == 8'h41) ? 35'h2 : (a == 8'h2F) ? 35'h100 : 35'h0;
            step;
        end
        cfg_we = 1'b0;
        step;
        nvec++; if (cnt(3, t0 + 1, cyc - 1) != 0) begin nmis++; $display("FAIL cfg_idle_err got %0d pulses required 0", cnt(3, t0 + 1, cyc - 1)); end
        pkt[0] = 8'h41; pkt[1] = 8'h2F; pkt[2] = 8'h2F;
        drive_pkt(3, -1, 0, -1, -1, t);
        repeat (10) step;
        nvec++; if (sod_l[(t+1)%LOGN] !== 1'b1) begin nmis++; $display("FAIL stream_sod_T1 got %b required 1", sod_l[(t+1)%LOGN]); end
        nvec++; if (cnt(1, t, t + 8) != 1) begin nmis++; $display("FAIL stream_sod_count got %0d required 1", cnt(1, t, t + 8)); end
        nvec++; if (en_l[(t+2)%LOGN] !== 1'b0) begin nmis++; $display("FAIL stream_en_T2 got %b required 0", en_l[(t+2)%LOGN]); end
        nvec++; if (en_l[(t+3)%LOGN] !== 1'b1 || cc_l[(t+3)%LOGN] !== 35'h2) begin nmis++; $display("FAIL stream_byte0 en=%b class=%h required en=1 class=2", en_l[(t+3)%LOGN], cc_l[(t+3)%LOGN]); end
        nvec++; if (en_l[(t+4)%LOGN] !== 1'b1 || cc_l[(t+4)%LOGN] !== 35'h100) begin nmis++; $display("FAIL stream_byte1 en=%b class=%h required en=1 class=100", en_l[(t+4)%LOGN], cc_l[(t+4)%LOGN]); end
        nvec++; if (en_l[(t+5)%LOGN] !== 1'b1 || cc_l[(t+5)%LOGN] !== 35'h100) begin nmis++; $display("FAIL stream_byte2 en=%b class=%h required en=1 class=100", en_l[(t+5)%LOGN], cc_l[(t+5)%LOGN]); end
        nvec++; if (en_l[(t+6)%LOGN] !== 1'b0) begin nmis++; $display("FAIL stream_en_T6 got %b required 0", en_l[(t+6)%LOGN]); end
        nvec++; if (eod_l[(t+6)%LOGN] !== 1'b0 || eod_l[(t+7)%LOGN] !== 1'b1) begin nmis++; $display("FAIL stream_eod T6=%b T7=%b required T6=0 T7=1", eod_l[(t+6)%LOGN], eod_l[(t+7)%LOGN]); end
        nvec++; if (cnt(2, t, t + 10) != 1) begin nmis++; $display("FAIL stream_eod_count got %0d required 1", cnt(2, t, t + 10)); end
        nvec++; if (cnt(3, t, t + 10) != 0) begin nmis++; $display("FAIL stream_err_count got %0d required 0", cnt(3, t, t + 10)); end
    endtask

    task automatic test_single_and_bubbles;
        int t;
        pkt[0] = 8'h41;
        drive_pkt(1, -1, 0, -1, -1, t);
        repeat (8) step;
        nvec++; if (sod_l[(t+1)%LOGN] !== 1'b1) begin nmis++; $display("FAIL single_sod got %b required 1", sod_l[(t+1)%LOGN]); end
        nvec++; if (cnt(0, t, t + 8) != 1 || en_l[(t+3)%LOGN] !== 1'b1 || cc_l[(t+3)%LOGN] !== 35'h2) begin nmis++; $display("FAIL single_en count=%0d en_T3=%b class=%h required 1,1,2", cnt(0, t, t + 8), en_l[(t+3)%LOGN], cc_l[(t+3)%LOGN]); end
        nvec++; if (eod_l[(t+5)%LOGN] !== 1'b1 || cnt(2, t, t + 8) != 1) begin nmis++; $display("FAIL single_eod T5=%b count=%0d required 1,1", eod_l[(t+5)%LOGN], cnt(2, t, t + 8)); end

        pkt[0] = 8'h41; pkt[1] = 8'h2F; pkt[2] = 8'h41; pkt[3] = 8'h2F;
        drive_pkt(4, 2, 2, -1, -1, t);
        repeat (8) step;
        nvec++; if (cnt(0, t, t + 12) != 4) begin nmis++; $display("FAIL bubble_en_count got %0d required 4", cnt(0, t, t + 12)); end
        nvec++; if (en_l[(t+5)%LOGN] !== 1'b0 || en_l[(t+6)%LOGN] !== 1'b0) begin nmis++; $display("FAIL bubble_gap T5=%b T6=%b required 0,0", en_l[(t+5)%LOGN], en_l[(t+6)%LOGN]); end
        nvec++; if (en_l[(t+7)%LOGN] !== 1'b1 || cc_l[(t+7)%LOGN] !== 35'h2) begin nmis++; $display("FAIL bubble_resume en=%b class=%h required 1,2", en_l[(t+7)%LOGN], cc_l[(t+7)%LOGN]); end
        nvec++; if (eod_l[(t+10)%LOGN] !== 1'b1) begin nmis++; $display("FAIL bubble_eod got %b required 1", eod_l[(t+10)%LOGN]); end
    endtask

    task automatic test_protocol_errors;
        int t0;
        int t;
        s_valid = 1'b1; s_sop = 1'b0; s_eop = 1'b0; s_data = 8'h2F;
        t0 = cyc;
        @(negedge clk);
        nvec++; if (s_ready !== 1'b1) begin nmis++; $display("FAIL orphan_ready got %b required 1", s_ready); end
        step;
        s_data = 8'h41;
        step;
        s_valid = 1'b0;
        repeat (6) step;
        nvec++; if (cnt(3, t0, t0 + 5) != 2 || err_l[(t0+1)%LOGN] !== 1'b1) begin nmis++; $display("FAIL orphan_err count=%0d T1=%b required 2,1", cnt(3, t0, t0 + 5), err_l[(t0+1)%LOGN]); end
        nvec++; if (cnt(0, t0, t0 + 5) != 0 || cnt(1, t0, t0 + 5) != 0) begin nmis++; $display("FAIL orphan_quiet en=%0d sod=%0d required 0,0", cnt(0, t0, t0 + 5), cnt(1, t0, t0 + 5)); end

        pkt[0] = 8'h2F; pkt[1] = 8'h41; pkt[2] = 8'h2F;
        drive_pkt(3, -1, 0, 1, -1, t);
        repeat (8) step;
        nvec++; if (cnt(3, t, t + 9) != 1 || err_l[(t+4)%LOGN] !== 1'b1) begin nmis++; $display("FAIL midsop_err count=%0d T4=%b required 1,1", cnt(3, t, t + 9), err_l[(t+4)%LOGN]); end
        nvec++; if (cnt(1, t, t + 9) != 1) begin nmis++; $display("FAIL midsop_sod_count got %0d required 1", cnt(1, t, t + 9)); end
        nvec++; if (cnt(0, t, t + 9) != 3 || cc_l[(t+4)%LOGN] !== 35'h2) begin nmis++; $display("FAIL midsop_en count=%0d class=%h required 3,2", cnt(0, t, t + 9), cc_l[(t+4)%LOGN]); end
        nvec++; if (eod_l[(t+7)%LOGN] !== 1'b1) begin nmis++; $display("FAIL midsop_eod got %b required 1", eod_l[(t+7)%LOGN]); end
    endtask

    task automatic test_config_lockout;
        int t;
        pkt[0] = 8'h41; pkt[1] = 8'h2F; pkt[2] = 8'h41;
        drive_pkt(3, -1, 0, -1, 1, t);
        repeat (8) step;
        nvec++; if (cnt(3, t, t + 9) != 1 || err_l[(t+4)%LOGN] !== 1'b1) begin nmis++; $display("FAIL lockout_err count=%0d T4=%b required 1,1", cnt(3, t, t + 9), err_l[(t+4)%LOGN]); end
        nvec++; if (cc_l[(t+5)%LOGN] !== 35'h2) begin nmis++; $display("FAIL lockout_same_pkt class=%h required 2", cc_l[(t+5)%LOGN]); end
        pkt[0] = 8'h41;
        drive_pkt(1, -1, 0, -1, -1, t);
        repeat (8) step;
        nvec++; if (en_l[(t+3)%LOGN] !== 1'b1 || cc_l[(t+3)%LOGN] !== 35'h2) begin nmis++; $display("FAIL lockout_next_pkt en=%b class=%h required 1,2", en_l[(t+3)%LOGN], cc_l[(t+3)%LOGN]); end
    endtask

    task automatic test_reset_mid_packet;
        int t;
        s_valid = 1'b1; s_sop = 1'b1; s_eop = 1'b0; s_data = 8'h41;
        t = cyc;
        repeat (3) step;
        s_sop = 1'b0; s_data = 8'h2F;
        step;
        s_data = 8'h41; rst = 1'b1;
        @(negedge clk);
        nvec++; if (s_ready !== 1'b0) begin nmis++; $display("FAIL rstmid_ready_in_rst got %b required 0", s_ready); end
        step;
        rst = 1'b0;
        step;
        s_data = 8'h2F;
        step;
        s_data = 8'h41;
        step;
        s_valid = 1'b0;
        repeat (8) step;
        nvec++; if (en_l[(t+5)%LOGN] !== 1'b0 || sod_l[(t+5)%LOGN] !== 1'b0 || eod_l[(t+5)%LOGN] !== 1'b0 || err_l[(t+5)%LOGN] !== 1'b0 || cc_l[(t+5)%LOGN] !== '0)
            begin nmis++; $display("FAIL rstmid_outputs en=%b sod=%b eod=%b err=%b class=%h required all 0", en_l[(t+5)%LOGN], sod_l[(t+5)%LOGN], eod_l[(t+5)%LOGN], err_l[(t+5)%LOGN], cc_l[(t+5)%LOGN]); end
        nvec++; if (cnt(2, t, t + 14) != 0) begin nmis++; $display("FAIL rstmid_eod_count got %0d required 0", cnt(2, t, t + 14)); end
        nvec++; if (cnt(3, t + 5, t + 14) != 3) begin nmis++; $display("FAIL rstmid_orphan_err got %0d required 3", cnt(3, t + 5, t + 14)); end
        nvec++; if (cnt(0, t + 5, t + 14) != 0) begin nmis++; $display("FAIL rstmid_en_after got %0d required 0", cnt(0, t + 5, t + 14)); end
        pkt[0] = 8'h2F;
        drive_pkt(1, -1, 0, -1, -1, t);
        repeat (8) step;
        nvec++; if (sod_l[(t+1)%LOGN] !== 1'b1 || en_l[(t+3)%LOGN] !== 1'b1 || cc_l[(t+3)%LOGN] !== 35'h100 || eod_l[(t+5)%LOGN] !== 1'b1)
            begin nmis++; $display("FAIL rstmid_next_pkt sod=%b en=%b class=%h eod=%b required 1,1,100,1", sod_l[(t+1)%LOGN], en_l[(t+3)%LOGN], cc_l[(t+3)%LOGN], eod_l[(t+5)%LOGN]); end
    endtask

`ifdef PAYLOAD_FEEDER_BYTE_CNT_EN
    task automatic test_byte_cnt;
        int t;
        bit seen;
        s_valid = 1'b1; s_sop = 1'b1; s_eop = 1'b0; s_data = 8'h00;
        repeat (3) step;
        s_sop = 1'b0;
        for (int i = 1; i < 70000; i++) begin
            s_eop = (i == 69999);
            step;
        end
        s_valid = 1'b0; s_eop = 1'b0;
        seen = 1'b0;
        for (int g = 0; g < 10 && !seen; g++) begin
            @(negedge clk);
            if (eod) begin
                seen = 1'b1;
                nvec++; if (byte_cnt !== 16'hFFFF) begin nmis++; $display("FAIL cnt_saturate got %h required ffff", byte_cnt); end
            end
        end
        if (!seen) begin nvec++; nmis++; $display("FAIL cnt_saturate_eod no eod within 10 cycles, required one"); end
        step;
        for (int i = 0; i < 10; i++) pkt[i] = 8'(i);
        drive_pkt(10, -1, 0, -1, -1, t);
        seen = 1'b0;
        for (int g = 0; g < 10 && !seen; g++) begin
            @(negedge clk);
            if (eod) begin
                seen = 1'b1;
                nvec++; if (byte_cnt !== 16'd10) begin nmis++; $display("FAIL cnt_ten got %0d required 10", byte_cnt); end
            end
        end
        if (!seen) begin nvec++; nmis++; $display("FAIL cnt_ten_eod no eod within 10 cycles, required one"); end
        step;
    endtask
`endif

    initial begin
        test_reset;
        test_program_stream;
        test_single_and_bubbles;
        test_protocol_errors;
        test_config_lockout;
        test_reset_mid_packet;
`ifdef PAYLOAD_FEEDER_BYTE_CNT_EN
        test_byte_cnt;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
